// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction codes and the longest encoding in bytes.
package y86_pkg;

    localparam int IMAX_LEN = 6;

    typedef logic [3:0] icode_t;

    localparam icode_t I_HALT   = 4'h0;
    localparam icode_t I_NOP    = 4'h1;
    localparam icode_t I_RRMOVL = 4'h2;
    localparam icode_t I_IRMOVL = 4'h3;
    localparam icode_t I_RMMOVL = 4'h4;
    localparam icode_t I_MRMOVL = 4'h5;
    localparam icode_t I_OPL    = 4'h6;
    localparam icode_t I_JXX    = 4'h7;
    localparam icode_t I_CALL   = 4'h8;
    localparam icode_t I_RET    = 4'h9;
    localparam icode_t I_PUSHL  = 4'hA;
    localparam icode_t I_POPL   = 4'hB;

endpackage

// File: rtl/ilen_decode.sv
// Combinational icode -> instruction length decode; undefined codes decode as
// 1-byte instructions with invalid set.
module ilen_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic [2:0] ilen,
    output logic       invalid
);

    always_comb begin
        ilen    = 3'd1;
        invalid = 1'b0;
        case (icode)
            I_HALT, I_NOP, I_RET:               ilen = 3'd1;
            I_RRMOVL, I_OPL, I_PUSHL, I_POPL:   ilen = 3'd2;
            I_JXX, I_CALL:                      ilen = 3'd5;
            I_IRMOVL, I_RMMOVL, I_MRMOVL:       ilen = 3'd6;
            default:                            invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/ifetch_align.sv
// Byte-serial instruction fetch feeding an alignment buffer; presents the head
// instruction as B0..B5 with pc/valP/ilen, and handles redirect and halt.
module ifetch_align
    import y86_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_BYTES = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_rd,
    input  logic [7:0]  imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  B0,
    output logic [7:0]  B1,
    output logic [7:0]  B2,
    output logic [7:0]  B3,
    output logic [7:0]  B4,
    output logic [7:0]  B5,
    output logic [2:0]  ilen,
    output logic [31:0] pc,
    output logic [31:0] valP,
    output logic        instr_invalid,
    output logic        halted
);

    localparam int CW = $clog2(BUF_BYTES + 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   head_pc_q, head_pc_d;
    logic [7:0]    abuf_q [BUF_BYTES];
    logic [7:0]    abuf_d [BUF_BYTES];
    logic [CW-1:0] count_q, count_d;
    logic          inflight_q;
    logic          kill_q, kill_d;
    logic          halted_q, halted_d;

    logic [2:0]    head_len;
    logic          head_invalid;
    logic          fire;
    logic          is_halt;
    logic          append;
    logic [CW-1:0] consumed;
    logic [CW-1:0] wr_idx;
    logic [CW:0]   occupancy;
    logic [7:0]    out_bytes [IMAX_LEN];

    ilen_decode u_ilen_decode (
        .icode   (abuf_q[0][7:4]),
        .ilen    (head_len),
        .invalid (head_invalid)
    );

    // Counting in-flight bytes against the depth reserves a slot for every
    // byte already requested, so an append can never overflow.
    assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign imem_rd   = !rst && !halted_q && !redirect && (occupancy < (CW+1)'(BUF_BYTES));
    assign imem_addr = fetch_pc_q;

    assign out_valid = (count_q != '0) && (count_q >= CW'(head_len)) && !halted_q;
    assign fire      = out_valid && out_ready;
    assign is_halt   = (abuf_q[0][7:4] == I_HALT);
    assign consumed  = fire ? CW'(head_len) : '0;
    assign append    = inflight_q && !kill_q;
    assign wr_idx    = count_q - consumed;

    always_comb begin
        for (int i = 0; i < BUF_BYTES; i++) begin
            abuf_d[i] = 8'h00;
            for (int j = 0; j < BUF_BYTES; j++) begin
                if (j - i == int'(consumed)) abuf_d[i] = abuf_q[j];
            end
            if (append && (CW'(i) == wr_idx)) abuf_d[i] = imem_rdata;
        end
        count_d    = count_q - consumed + {{(CW-1){1'b0}}, append};
        fetch_pc_d = imem_rd ? fetch_pc_q + 32'd1 : fetch_pc_q;
        head_pc_d  = fire ? head_pc_q + {29'd0, head_len} : head_pc_q;
        halted_d   = halted_q;
        kill_d     = 1'b0;

        if (redirect) begin
            for (int i = 0; i < BUF_BYTES; i++) abuf_d[i] = 8'h00;
            count_d    = '0;
            fetch_pc_d = redirect_pc;
            head_pc_d  = redirect_pc;
            halted_d   = 1'b0;
            kill_d     = inflight_q;
        end else if (fire && is_halt) begin
            // The read issued alongside the halt transfer must not land later.
            for (int i = 0; i < BUF_BYTES; i++) abuf_d[i] = 8'h00;
            count_d  = '0;
            halted_d = 1'b1;
            kill_d   = imem_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_BYTES; i++) abuf_q[i] <= 8'h00;
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
            count_q    <= '0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            for (int i = 0; i < BUF_BYTES; i++) abuf_q[i] <= abuf_d[i];
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
            count_q    <= count_d;
            inflight_q <= imem_rd;
            kill_q     <= kill_d;
            halted_q   <= halted_d;
        end
    end

    always_comb begin
        for (int i = 0; i < IMAX_LEN; i++) begin
            out_bytes[i] = (i < int'(head_len)) ? abuf_q[i] : 8'h00;
        end
    end

    assign B0            = out_bytes[0];
    assign B1            = out_bytes[1];
    assign B2            = out_bytes[2];
    assign B3            = out_bytes[3];
    assign B4            = out_bytes[4];
    assign B5            = out_bytes[5];
    assign ilen          = head_len;
    assign pc            = head_pc_q;
    assign valP          = head_pc_q + {29'd0, head_len};
    assign instr_invalid = head_invalid;
    assign halted        = halted_q;

endmodule

// File: tb/tb_ifetch_align.sv
// Directed bench for ifetch_align: byte memory model, per-scenario tasks with
// hand-computed expectations.
module tb_ifetch_align;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_rd;
    logic [7:0]  imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  B0, B1, B2, B3, B4, B5;
    logic [2:0]  ilen;
    logic [31:0] pc;
    logic [31:0] valP;
    logic        instr_invalid;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] valp;
        logic [2:0]  ilen;
        logic        inv;
        logic [47:0] bytes;
        int          cyc;
    } xfer_t;

    xfer_t cap[$];
    logic [7:0] mem [256];

    always #5 clk = ~clk;

    ifetch_align #(.RESET_PC(32'h0000_0000), .BUF_BYTES(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_rd       (imem_rd),
        .imem_rdata    (imem_rdata),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .B0            (B0),
        .B1            (B1),
        .B2            (B2),
        .B3            (B3),
        .B4            (B4),
        .B5            (B5),
        .ilen          (ilen),
        .pc            (pc),
        .valP          (valP),
        .instr_invalid (instr_invalid),
        .halted        (halted)
    );

    always @(posedge clk) begin
        if (imem_rd) imem_rdata <= mem[imem_addr[7:0]];
    end

    task automatic step();
        xfer_t x;
        if (out_valid && out_ready) begin
            x.pc = pc; x.valp = valP; x.ilen = ilen; x.inv = instr_invalid;
            x.bytes = {B0, B1, B2, B3, B4, B5}; x.cyc = cyc;
            cap.push_back(x);
        end
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic fill_mem(input logic [7:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        repeat (3) begin @(posedge clk); #2; end
        rst = 1'b0;
        cyc = 0;
        cap.delete();
        #1;
    endtask

    task automatic test_reset();
        fill_mem(8'h10);
        out_ready = 1'b0;
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        repeat (3) begin @(posedge clk); #2; end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_cmp++; if (imem_rd !== 1'b0) begin n_err++; $display("FAIL reset_imem_rd: got %0b want 0", imem_rd); end
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 00000000", pc); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_imem_addr: got %h want 00000000", imem_addr); end
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %0b want 0", halted); end
        n_cmp++; if ({B0, B1, B2, B3, B4, B5} !== 48'h0) begin n_err++; $display("FAIL reset_bytes: got %h want 0", {B0, B1, B2, B3, B4, B5}); end
        n_cmp++; if (ilen !== 3'd1) begin n_err++; $display("FAIL reset_ilen: got %0d want 1", ilen); end
        n_cmp++; if (valP !== 32'h1) begin n_err++; $display("FAIL reset_valP: got %h want 00000001", valP); end
        rst = 1'b0;
        cyc = 0;
        #1;
        n_cmp++; if (imem_rd !== 1'b1) begin n_err++; $display("FAIL startup_imem_rd: got %0b want 1", imem_rd); end
    endtask

    task automatic test_nop_halt();
        logic [31:0] exp_pc [3] = '{32'd0, 32'd1, 32'd2};
        logic [7:0]  exp_b0 [3] = '{8'h10, 8'h10, 8'h00};
        int          exp_cy [3] = '{2, 3, 4};
        fill_mem(8'h10);
        mem[2] = 8'h00;
        out_ready = 1'b1;
        do_reset();
        while (!halted && cyc < 30) step();
        n_cmp++; if (cap.size() != 3) begin n_err++; $display("FAIL nh_count: got %0d transfers want 3", cap.size()); end
        for (int k = 0; k < 3 && k < cap.size(); k++) begin
            n_cmp++; if (cap[k].pc !== exp_pc[k]) begin n_err++; $display("FAIL nh_pc[%0d]: got %h want %h", k, cap[k].pc, exp_pc[k]); end
            n_cmp++; if (cap[k].valp !== exp_pc[k] + 32'd1) begin n_err++; $display("FAIL nh_valP[%0d]: got %h want %h", k, cap[k].valp, exp_pc[k] + 32'd1); end
            n_cmp++; if (cap[k].bytes[47:40] !== exp_b0[k]) begin n_err++; $display("FAIL nh_B0[%0d]: got %h want %h", k, cap[k].bytes[47:40], exp_b0[k]); end
            n_cmp++; if (cap[k].cyc != exp_cy[k]) begin n_err++; $display("FAIL nh_cycle[%0d]: got %0d want %0d", k, cap[k].cyc, exp_cy[k]); end
        end
        repeat (5) begin
            n_cmp++; if (halted !== 1'b1 || imem_rd !== 1'b0 || out_valid !== 1'b0) begin
                n_err++; $display("FAIL nh_halted: got halted=%0b rd=%0b valid=%0b want 1 0 0", halted, imem_rd, out_valid);
            end
            step();
        end
    endtask

    task automatic test_irmovl();
        fill_mem(8'h10);
        mem[0] = 8'h30; mem[1] = 8'hF3; mem[2] = 8'h78;
        mem[3] = 8'h56; mem[4] = 8'h34; mem[5] = 8'h12;
        out_ready = 1'b0;
        do_reset();
        while (!out_valid && cyc < 20) step();
        n_cmp++; if (cyc != 7) begin n_err++; $display("FAIL ir_latency: got valid at cycle %0d want 7", cyc); end
        n_cmp++; if ({B0, B1, B2, B3, B4, B5} !== 48'h30F378563412) begin n_err++; $display("FAIL ir_bytes: got %h want 30f378563412", {B0, B1, B2, B3, B4, B5}); end
        n_cmp++; if (ilen !== 3'd6) begin n_err++; $display("FAIL ir_ilen: got %0d want 6", ilen); end
        n_cmp++; if (valP !== 32'd6) begin n_err++; $display("FAIL ir_valP: got %h want 00000006", valP); end
        n_cmp++; if (pc !== 32'd0 || instr_invalid !== 1'b0) begin n_err++; $display("FAIL ir_pc_inv: got %h/%0b want 00000000/0", pc, instr_invalid); end
    endtask

    task automatic test_backpressure();
        fill_mem(8'h10);
        out_ready = 1'b0;
        do_reset();
        while (cyc < 20) begin
            n_cmp++; if (imem_rd !== (cyc <= 7)) begin n_err++; $display("FAIL bp_imem_rd: cycle %0d got %0b want %0b", cyc, imem_rd, (cyc <= 7)); end
            step();
        end
        n_cmp++; if (dut.count_q !== 4'd8) begin n_err++; $display("FAIL bp_count: got %0d want 8", dut.count_q); end
        n_cmp++; if (cap.size() != 0) begin n_err++; $display("FAIL bp_no_xfer: got %0d transfers want 0", cap.size()); end
        out_ready = 1'b1;
        repeat (16) step();
        n_cmp++; if (cap.size() != 16) begin n_err++; $display("FAIL bp_drain_count: got %0d want 16", cap.size()); end
        for (int k = 0; k < cap.size(); k++) begin
            n_cmp++; if (cap[k].pc !== k || cap[k].bytes[47:40] !== 8'h10 || cap[k].cyc != 20 + k) begin
                n_err++; $display("FAIL bp_drain[%0d]: got pc=%h b0=%h cyc=%0d want pc=%h b0=10 cyc=%0d", k, cap[k].pc, cap[k].bytes[47:40], cap[k].cyc, k, 20 + k);
            end
        end
    endtask

    task automatic test_redirect();
        fill_mem(8'h10);
        mem[8'h40] = 8'h20; mem[8'h41] = 8'h12;
        out_ready = 1'b1;
        do_reset();
        repeat (3) step();
        n_cmp++; if (dut.inflight_q !== 1'b1) begin n_err++; $display("FAIL rd_inflight: got %0b want 1", dut.inflight_q); end
        redirect = 1'b1; redirect_pc = 32'h40;
        #1;
        n_cmp++; if (imem_rd !== 1'b0) begin n_err++; $display("FAIL rd_rd_during: got %0b want 0", imem_rd); end
        step();
        redirect = 1'b0;
        cap.delete();
        #1;
        n_cmp++; if (imem_rd !== 1'b1 || imem_addr !== 32'h40) begin n_err++; $display("FAIL rd_first_read: got rd=%0b addr=%h want 1 00000040", imem_rd, imem_addr); end
        while (cap.size() < 2 && cyc < 30) step();
        n_cmp++;
        if (cap.size() < 2) begin
            n_err++; $display("FAIL rd_timeout: got %0d transfers want 2", cap.size());
        end else begin
            n_cmp++; if (cap[0].cyc != 7) begin n_err++; $display("FAIL rd_latency: got cycle %0d want 7", cap[0].cyc); end
            n_cmp++; if (cap[0].pc !== 32'h40 || cap[0].valp !== 32'h42) begin n_err++; $display("FAIL rd_pc: got %h/%h want 00000040/00000042", cap[0].pc, cap[0].valp); end
            n_cmp++; if (cap[0].bytes !== 48'h201200000000 || cap[0].ilen !== 3'd2) begin n_err++; $display("FAIL rd_bytes: got %h len %0d want 201200000000 len 2", cap[0].bytes, cap[0].ilen); end
            n_cmp++; if (cap[1].pc !== 32'h42 || cap[1].bytes[47:40] !== 8'h10) begin n_err++; $display("FAIL rd_next: got %h/%h want 00000042/10", cap[1].pc, cap[1].bytes[47:40]); end
        end
    endtask

    task automatic test_halt_redirect();
        fill_mem(8'h10);
        mem[1] = 8'h00;
        mem[8'h10] = 8'h61; mem[8'h11] = 8'h23;
        out_ready = 1'b1;
        do_reset();
        while (!halted && cyc < 30) step();
        repeat (3) step();
        n_cmp++; if (halted !== 1'b1 || imem_rd !== 1'b0) begin n_err++; $display("FAIL hr_halted: got halted=%0b rd=%0b want 1 0", halted, imem_rd); end
        redirect = 1'b1; redirect_pc = 32'h10;
        #1;
        n_cmp++; if (imem_rd !== 1'b0) begin n_err++; $display("FAIL hr_rd_during: got %0b want 0", imem_rd); end
        step();
        redirect = 1'b0;
        cap.delete();
        #1;
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL hr_clear: got halted=%0b want 0", halted); end
        n_cmp++; if (imem_rd !== 1'b1 || imem_addr !== 32'h10) begin n_err++; $display("FAIL hr_resume: got rd=%0b addr=%h want 1 00000010", imem_rd, imem_addr); end
        while (cap.size() < 1 && cyc < 40) step();
        n_cmp++;
        if (cap.size() < 1) begin
            n_err++; $display("FAIL hr_timeout: got no transfer want one");
        end else begin
            n_cmp++; if (cap[0].pc !== 32'h10 || cap[0].bytes !== 48'h612300000000 || cap[0].ilen !== 3'd2) begin
                n_err++; $display("FAIL hr_first: got pc=%h bytes=%h len=%0d want 00000010 612300000000 2", cap[0].pc, cap[0].bytes, cap[0].ilen);
            end
        end
    endtask

    task automatic test_invalid();
        fill_mem(8'h10);
        mem[0] = 8'hE0; mem[1] = 8'h20; mem[2] = 8'h34;
        out_ready = 1'b0;
        do_reset();
        repeat (6) step();
        out_ready = 1'b1;
        while (cap.size() < 3 && cyc < 30) step();
        n_cmp++;
        if (cap.size() < 3) begin
            n_err++; $display("FAIL inv_timeout: got %0d transfers want 3", cap.size());
        end else begin
            n_cmp++; if (cap[0].pc !== 32'h0 || cap[0].ilen !== 3'd1 || cap[0].inv !== 1'b1) begin n_err++; $display("FAIL inv_head: got pc=%h len=%0d inv=%0b want 0 1 1", cap[0].pc, cap[0].ilen, cap[0].inv); end
            n_cmp++; if (cap[0].bytes !== 48'hE00000000000) begin n_err++; $display("FAIL inv_bytes: got %h want e00000000000", cap[0].bytes); end
            n_cmp++; if (cap[1].pc !== 32'h1 || cap[1].ilen !== 3'd2 || cap[1].inv !== 1'b0 || cap[1].valp !== 32'h3) begin n_err++; $display("FAIL inv_next: got pc=%h len=%0d inv=%0b valP=%h want 1 2 0 3", cap[1].pc, cap[1].ilen, cap[1].inv, cap[1].valp); end
            n_cmp++; if (cap[1].bytes !== 48'h203400000000) begin n_err++; $display("FAIL inv_next_bytes: got %h want 203400000000", cap[1].bytes); end
            n_cmp++; if (cap[2].pc !== 32'h3 || cap[2].bytes[47:40] !== 8'h10) begin n_err++; $display("FAIL inv_third: got pc=%h b0=%h want 3 10", cap[2].pc, cap[2].bytes[47:40]); end
        end
    endtask

    initial begin
        imem_rdata = 8'h00;
        test_reset();
        test_nop_halt();
        test_irmovl();
        test_backpressure();
        test_redirect();
        test_halt_redirect();
        test_invalid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ifetch_align.md
# ifetch_align

Byte-serial instruction fetch and alignment stage for the Y86 core. It reads instruction memory one byte per cycle into an 8-byte alignment buffer. Once the head instruction is complete, it presents up to six bytes on `B0`..`B5` together with `pc`, `valP` and the decoded length, which is the exact input form consumed by the instruction splitter directly downstream. It also handles control-flow redirects and halt.

## Interface
- `RESET_PC`, 32'h0000_0000: fetch address loaded on reset.
- `BUF_BYTES`, 8: alignment buffer depth in bytes; must be ≥ 7.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `imem_addr` output 32: byte address of the current read.
- `imem_rd` output 1: read strobe; one byte is requested per asserted cycle.
- `imem_rdata` input 8: read data, valid exactly 1 cycle after its `imem_rd`.
- `redirect` input 1: load a new fetch PC and flush all state.
- `redirect_pc` input 32: target of `redirect`.
- `out_valid` output 1: the head instruction is complete on `B0`..`B5`.
- `out_ready` input 1: downstream accepts; a transfer occurs when `out_valid` and `out_ready` are both high.
- `B0`..`B5` output 8 each: head instruction bytes in memory order; bytes at or beyond `ilen` are driven 0.
- `ilen` output 3: head instruction length, 1..6.
- `pc` output 32: address of `B0`.
- `valP` output 32: `pc + ilen`, mod 2^32.
- `instr_invalid` output 1: the head icode is undefined (valid only with `out_valid`).
- `halted` output 1: a halt instruction has been delivered and fetch is stopped.

## Operation
- Length from `B0[7:4]`:
  - 0 halt, 1 nop, 9 ret: 1 byte.
  - 2 rrmovl/cmov, 6 OPl, A pushl, B popl: 2 bytes.
  - 7 jXX, 8 call: 5 bytes.
  - 3 irmovl, 4 rmmovl, 5 mrmovl: 6 bytes.
  - C..F: 1 byte, with `instr_invalid` set.
- State:
  - `fetch_pc`: next address to read.
  - `buf[0..BUF_BYTES-1]` and `count` (0..BUF_BYTES).
  - `inflight`: registered copy of `imem_rd`.
  - `kill`: drop the next returning byte.
  - `head_pc`.
  - `halted`.
- `imem_rd = !halted && !redirect && (count + inflight < BUF_BYTES)`. `imem_addr = fetch_pc`. `fetch_pc` increments on each read.
- Returning byte: when `inflight && !kill`, append it at `buf[count - consumed]`.
- `out_valid = count ≥ 1 && count ≥ ilen(buf[0]) && !halted`.
- On a transfer:
  - Shift the buffer left by `ilen` and reduce `count` by `ilen`.
  - `head_pc ← head_pc + ilen`.
  - A byte arriving in the same cycle lands at the post-shift position.
- Halt transfer (icode 0):
  - `halted ← 1` next cycle.
  - Buffer flushed, `count ← 0`, any in-flight byte killed.
  - `imem_rd` stays 0 until `redirect` or `rst`.
- `redirect` has priority over all other events. Next cycle:
  - `count ← 0`, `fetch_pc ← redirect_pc`, `head_pc ← redirect_pc`.
  - `halted ← 0`, `kill ← inflight`.
  - A transfer in the same cycle still counts as delivered; its buffer effect is discarded.
- Invalid icode: the instruction is still delivered as 1 byte. Fetch continues.

## Timing
- Reset values: `out_valid` 0, `imem_rd` 0 while `rst` is high, `count` 0, `fetch_pc` and `pc` = `RESET_PC`, `halted` 0, `kill` 0, `B0`..`B5` 0, `ilen` 1, `valP` = `RESET_PC + 1`.
- Cycle numbering: cycle 0 is the first cycle with `rst` low.
- Startup: `imem_rd` is high from cycle 0. The byte requested in cycle n is in the buffer from cycle n+2.
- First instruction latency: `out_valid` rises in cycle `ilen + 1` (1-byte instruction: cycle 2; 6-byte: cycle 7).
- Steady state:
  - Fetch sustains 1 byte/cycle.
  - The buffer never overflows, because the `count + inflight` bound guarantees a slot for every in-flight byte.
  - Back-pressure stalls reads once `count + inflight = BUF_BYTES`.
- Redirect takes effect as if reset to `redirect_pc`: first read in the next cycle, `out_valid` at redirect cycle + `ilen` + 2.
- All outputs are functions of registers only, except `imem_rd` (which depends on `redirect`).

## Structure
- Shared package `y86_pkg`: icode constants (`I_HALT`..`I_POPL`) and `IMAX_LEN = 6`.
- Sub-module `ilen_decode`: combinational, icode → `{ilen[2:0], invalid}`. It is reused by the splitter-side decode checks.

## Test plan
- Reset with `RESET_PC=0`, memory `10 10 00`, `out_ready=1`:
  - Two nop transfers, with pc 0 and 1, valP 1 and 2.
  - Then halt at pc 2.
  - `halted=1` and `imem_rd=0` thereafter.
- Memory `30 F3 78 56 34 12` (irmovl):
  - `out_valid` rises in cycle 7.
  - `B0..B5 = 30 F3 78 56 34 12`, `ilen=6`, `valP=6`.
- `out_ready=0` for 20 cycles over a stream of nops:
  - `count` saturates at 8.
  - `imem_rd` is 0 while `count + inflight = 8`.
  - No byte is lost when `out_ready` rises.
- `redirect` to `0x40` while a read is in flight:
  - The stale byte is discarded.
  - The next delivered instruction has `pc=0x40` with bytes from `0x40`.
- Halted state, then `redirect` to `0x10`:
  - `halted` clears.
  - Fetch resumes at `0x10`.
- icode `E0`:
  - Delivered with `ilen=1` and `instr_invalid=1`.
  - The following instruction is aligned at pc+1.
